spi_slave_ram: RTL and testbench
================================

SPI_SLAVE_RAM -- requirements
Module: spi_slave_ram

Interface
REQ-001 Parameter MEM_DEPTH, default 256, number of RAM words.
REQ-002 Parameter ADDR_SIZE, default 8, RAM address width.
REQ-003 clk  input  1  single clock; all sampling and state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-high (asserted when 1, despite the name).
REQ-005 MOSI  input  1  serial data in, MSB first, one bit per clk.
REQ-006 SS_n  input  1  slave select; 1 = selected (frames active), 0 = idle/deselected.
REQ-007 MISO  output  1  serial read data out, MSB first.

Function
REQ-008 Block SHALL contain an SPI slave front end and a MEM_DEPTH x 8-bit single-port RAM, joined by internal rx_data[9:0], rx_valid, tx_data[7:0], tx_valid.
REQ-009 Frame SHALL be 10 bits: bits[9:8] command, bits[7:0] payload; bit 9 first.
REQ-010 While SS_n=1, MOSI SHALL be sampled every rising clk; a 4-bit counter SHALL count 0..9 and wrap to 0 after the 10th bit.
REQ-011 On the 10th sampled bit, rx_data SHALL hold the full frame and rx_valid SHALL pulse high for exactly one clk.
REQ-012 Frames SHALL be accepted back-to-back with no idle cycle; the bit after the 10th starts the next frame.
REQ-013 Command 00 (write address): on rx_valid, write_addr register SHALL load payload.
REQ-014 Command 01 (write data): on rx_valid, RAM[write_addr] SHALL load payload.
REQ-015 Command 10 (read address): on rx_valid, read_addr register SHALL load payload.
REQ-016 Command 11 (read data): payload is don't-care; on rx_valid, RAM SHALL place RAM[read_addr] on tx_data and pulse tx_valid one clk later.
REQ-017 On tx_valid, front end SHALL load tx_data into an 8-bit shift register and drive MISO with bits 7..0 on the next 8 clks, one bit per clk, concurrently with reception of any following frame.
REQ-018 MISO SHALL be 0 whenever no read-data byte is being shifted.
REQ-019 Controller states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA; IDLE->CHK_CMD when SS_n=1; CHK_CMD->WRITE if bit9=0, else READ_ADD if bit8=0, else READ_DATA; WRITE/READ_ADD/READ_DATA->CHK_CMD at frame end if SS_n=1.
REQ-020 SS_n=0 in any state SHALL force IDLE next clk, clear bit counter, discard the partial frame (no rx_valid) and abort any MISO shift (MISO=0).
REQ-021 Addresses are 8 bits; all 256 locations reachable; no address auto-increment.
REQ-022 Write-then-read of the same address in consecutive frames SHALL return the newly written data.

Reset
REQ-023 rst_n=1 SHALL asynchronously force state IDLE, bit counter 0, rx_data 0, rx_valid 0, tx_valid 0, tx_data 0, shift registers 0, write_addr 0, read_addr 0, MISO 0.
REQ-024 RAM contents SHALL NOT be altered by reset.
REQ-025 Deasserting rst_n SHALL allow a frame to begin on the first clk with SS_n=1.

Verification
REQ-026 Reset then SS_n=1, frames 00_0x05, 01_0xA5, 10_0x05, 11_0xEA -> RAM[0x05]=0xA5; MISO emits 1,0,1,0,0,1,0,1 over 8 clks after the read-data frame.
REQ-027 Loop j=0..255: frames 00_j, 01_j, 10_j, 11_0xEA -> MISO byte equals j each iteration; address 0xFF and 0x00 both correct.
REQ-028 Drop SS_n to 0 after 6 bits of a 01 frame -> no RAM write, state IDLE, MISO 0; next full frame decoded correctly.
REQ-029 Assert rst_n mid-frame and mid-MISO-shift -> outputs and registers at reset values immediately (before next clk edge); previously written RAM data still readable afterwards.
REQ-030 Two consecutive 11 frames with no gap -> same byte output twice, second byte starting one clk after second frame's rx_valid+1.

Source files
------------

// File: rtl/spi_slave_ram.sv
// ============================================================================
// Module   : spi_slave_ram
// Brief    : SPI slave front end (10-bit command frames) joined to an 8-bit RAM.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module spi_slave_ram #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic MOSI,
  input  logic SS_n,
  output logic MISO
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  localparam logic [3:0] c_LAST_BIT = 4'd9;
  localparam logic [3:0] c_CMD_BITS = 4'd2;

  state_t               r_state;
  state_t               w_next_state;
  logic [3:0]           r_bit_cnt;
  logic [8:0]           r_rx_shift;
  logic [9:0]           r_rx_data;
  logic                 r_rx_valid;
  logic [7:0]           r_tx_data;
  logic                 r_tx_valid;
  logic [7:0]           r_tx_shift;
  logic [ADDR_SIZE-1:0] r_write_addr;
  logic [ADDR_SIZE-1:0] r_read_addr;
  logic [7:0]           r_mem [MEM_DEPTH];

  // Controller tracks the frame phase; the command is known once two bits are in.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (!SS_n) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_next_state = CHK_CMD;
        CHK_CMD: begin
          if (r_bit_cnt == c_CMD_BITS) begin
            if (!r_rx_shift[1])      w_next_state = WRITE;
            else if (!r_rx_shift[0]) w_next_state = READ_ADD;
            else                     w_next_state = READ_DATA;
          end
        end
        WRITE, READ_ADD, READ_DATA: begin
          if (r_bit_cnt == c_LAST_BIT) w_next_state = CHK_CMD;
        end
        default: w_next_state = IDLE;
      endcase
    end
  end

  // Receive path and MISO shifter; deselect discards the partial frame and any shift.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_bit_cnt  <= 4'd0;
      r_rx_shift <= 9'd0;
      r_rx_data  <= 10'd0;
      r_rx_valid <= 1'b0;
      r_tx_shift <= 8'd0;
    end else begin
      r_rx_valid <= 1'b0;
      if (!SS_n) begin
        r_bit_cnt  <= 4'd0;
        r_tx_shift <= 8'd0;
      end else begin
        r_rx_shift <= {r_rx_shift[7:0], MOSI};
        if (r_bit_cnt == c_LAST_BIT) begin
          r_bit_cnt  <= 4'd0;
          r_rx_data  <= {r_rx_shift, MOSI};
          r_rx_valid <= 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end
        if (r_tx_valid) r_tx_shift <= r_tx_data;
        else            r_tx_shift <= {r_tx_shift[6:0], 1'b0};
      end
    end
  end

  // Zeros fill in behind the byte, so MISO returns to 0 once all 8 bits are out.
  assign MISO = r_tx_shift[7];

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_write_addr <= '0;
      r_read_addr  <= '0;
      r_tx_data    <= 8'd0;
      r_tx_valid   <= 1'b0;
    end else begin
      r_tx_valid <= 1'b0;
      if (r_rx_valid) begin
        case (r_rx_data[9:8])
          2'b00:   r_write_addr <= r_rx_data[ADDR_SIZE-1:0];
          2'b10:   r_read_addr  <= r_rx_data[ADDR_SIZE-1:0];
          2'b11: begin
            r_tx_data  <= r_mem[r_read_addr];
            r_tx_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // RAM array keeps its contents through reset.
  always_ff @(posedge clk) begin
    if (r_rx_valid && (r_rx_data[9:8] == 2'b01)) r_mem[r_write_addr] <= r_rx_data[7:0];
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_ram.sv
// ============================================================================
// Module   : tb_spi_slave_ram
// Brief    : Self-checking bench for spi_slave_ram against a frame-level RAM model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_spi_slave_ram;

  logic clk = 1'b0;
  logic rst_n;
  logic MOSI;
  logic SS_n;
  logic MISO;

  always #5 clk = ~clk;

  spi_slave_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .MOSI (MOSI),
    .SS_n (SS_n),
    .MISO (MISO)
  );

  typedef struct {
    int         start;
    logic [7:0] val;
  } win_t;

  int         checks   = 0;
  int         failures = 0;
  logic       samples [$];
  win_t       exp_q [$];
  logic [7:0] m_mem [256];
  logic [7:0] m_waddr;
  logic [7:0] m_raddr;
  bit         last_read;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    samples.push_back(MISO);
  endtask

  // A read-data frame whose last bit lands at sample e yields its byte at samples e+2..e+9.
  task automatic send_frame(input logic [1:0] cmd, input logic [7:0] pay, input int nbits = 10);
    logic [9:0] f;
    f    = {cmd, pay};
    SS_n = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      MOSI = f[9-i];
      tick();
    end
    if (nbits == 10) begin
      case (cmd)
        2'b00: m_waddr = pay;
        2'b01: m_mem[m_waddr] = pay;
        2'b10: m_raddr = pay;
        default: exp_q.push_back('{samples.size() + 1, m_mem[m_raddr]});
      endcase
    end
    last_read = (nbits == 10) && (cmd == 2'b11);
  endtask

  task automatic idle(input int n);
    SS_n = 1'b0;
    MOSI = 1'b0;
    repeat (n) tick();
  endtask

  task automatic check_phase(input string tag);
    bit mark [];
    int stray;
    mark = new[samples.size()];
    foreach (exp_q[k]) begin
      if (exp_q[k].start + 8 > samples.size()) begin
        chk({tag, "_window_len"}, samples.size(), exp_q[k].start + 8);
      end else begin
        logic [7:0] got;
        for (int b = 0; b < 8; b++) begin
          got[7-b] = samples[exp_q[k].start + b];
          mark[exp_q[k].start + b] = 1'b1;
        end
        chk($sformatf("%s_byte%0d", tag, k), got, exp_q[k].val);
      end
    end
    stray = 0;
    foreach (samples[i]) if (!mark[i] && (samples[i] !== 1'b0)) stray++;
    chk({tag, "_miso_quiet"}, stray, 0);
    samples.delete();
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b1;
    SS_n  = 1'b0;
    MOSI  = 1'b0;
    last_read = 1'b0;
    #3;
    chk("reset_miso", MISO, 0);
    repeat (3) tick();
    rst_n = 1'b0;
    samples.delete();
    m_waddr = 8'h00;
    m_raddr = 8'h00;

    // Basic write/read, first frame starts on the first clock after reset release
    send_frame(2'b00, 8'h05);
    send_frame(2'b01, 8'hA5);
    send_frame(2'b10, 8'h05);
    send_frame(2'b11, 8'hEA);
    send_frame(2'b10, 8'h05);
    begin
      logic [7:0] got;
      for (int b = 0; b < 8; b++) got[7-b] = samples[exp_q[0].start + b];
      chk("basic_a5_bits", got, 8'hA5);
    end
    idle(2);
    check_phase("basic");

    // Full address sweep, data equal to address
    for (int j = 0; j < 256; j++) begin
      send_frame(2'b00, 8'(j));
      send_frame(2'b01, 8'(j));
      send_frame(2'b10, 8'(j));
      send_frame(2'b11, 8'hEA);
    end
    send_frame(2'b10, 8'h00);
    idle(2);
    check_phase("sweep");

    // Random frames with occasional aborted partial frames
    for (int n = 0; n < 300; n++) begin
      if (!last_read && ($urandom_range(0, 7) == 0)) begin
        send_frame(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), int'($urandom_range(1, 9)));
        idle(int'($urandom_range(1, 3)));
      end else begin
        send_frame(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      end
    end
    send_frame(2'b10, 8'h00);
    idle(2);
    check_phase("random");

    // Deselect after 6 bits of a write-data frame must not write
    send_frame(2'b00, 8'h33);
    send_frame(2'b01, 8'h11);
    send_frame(2'b01, 8'h77, 6);
    idle(2);
    chk("abort_miso", MISO, 0);
    send_frame(2'b10, 8'h33);
    send_frame(2'b11, 8'h00);
    send_frame(2'b10, 8'h00);
    idle(2);
    check_phase("abort");

    // Two read-data frames back to back
    send_frame(2'b10, 8'h33);
    send_frame(2'b11, 8'h5A);
    send_frame(2'b11, 8'hC4);
    send_frame(2'b10, 8'h00);
    idle(2);
    check_phase("double_read");

    // Asynchronous reset mid-frame and mid-shift
    send_frame(2'b00, 8'hC3);
    send_frame(2'b01, 8'hFF);
    send_frame(2'b10, 8'hC3);
    send_frame(2'b11, 8'h00);
    SS_n = 1'b1;
    MOSI = 1'b1;
    repeat (4) tick();
    chk("pre_reset_miso", MISO, 1);
    rst_n = 1'b1;
    #1;
    chk("async_reset_miso", MISO, 0);
    repeat (2) tick();
    chk("held_reset_miso", MISO, 0);
    rst_n = 1'b0;
    samples.delete();
    exp_q.delete();
    m_waddr = 8'h00;
    m_raddr = 8'h00;
    send_frame(2'b11, 8'h00);
    send_frame(2'b10, 8'hC3);
    send_frame(2'b11, 8'h00);
    send_frame(2'b10, 8'h00);
    idle(2);
    check_phase("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
